// File: rtl/wvb_hdr_rr_sched.sv
// wvb_hdr_rr_sched
// Round-robin scheduler that shares one waveform-readout engine among
// N_CHAN per-channel waveform-buffer header FIFOs. It pops one header,
// presents it with its channel number, and waits for readout completion
// before granting again.
//
// Ports:
//   clk, rst_n     system clock; synchronous active-low reset
//   en             arbitration enable, gates new grants only
//   hdr_rdy        per-channel FIFO non-empty flags
//   hdr_data       per-channel FIFO read data, channel k at [k*HDR_W +: HDR_W]
//   hdr_rd_en      one-hot single-cycle FIFO pop
//   sel_hdr        captured header of the granted channel
//   sel_chan       granted channel index
//   sel_valid      sel_hdr/sel_chan valid
//   sel_ready      readout engine accepts the header
//   rdout_done     single-cycle pulse, readout of the granted buffer finished
//   tmo_limit      BUSY timeout in cycles, 0 disables the timeout
//   busy           high in every state except IDLE
//   tmo_err        single-cycle pulse when a BUSY wait is aborted by timeout
//   state_dbg      current FSM state encoding, for observation only
//
// Handshake: the header is transferred on a cycle where sel_valid and
// sel_ready are both 1. While sel_valid is 1 and sel_ready is 0, sel_hdr and
// sel_chan hold stable; sel_valid never drops without a transfer (except on
// reset). sel_ready is ignored while sel_valid is 0.

module wvb_hdr_rr_sched #(
  parameter int N_CHAN = 24,
  parameter int HDR_W  = 106,
  parameter int CHAN_W = 5,
  parameter int TMO_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [N_CHAN-1:0]        hdr_rdy,
  input  logic [N_CHAN*HDR_W-1:0]  hdr_data,
  output logic [N_CHAN-1:0]        hdr_rd_en,
  output logic [HDR_W-1:0]         sel_hdr,
  output logic [CHAN_W-1:0]        sel_chan,
  output logic                     sel_valid,
  input  logic                     sel_ready,
  input  logic                     rdout_done,
  input  logic [TMO_W-1:0]         tmo_limit,
  output logic                     busy,
  output logic                     tmo_err,
  output logic [2:0]               state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_POP     = 3'd1,
    S_FETCH   = 3'd2,
    S_PRESENT = 3'd3,
    S_BUSY    = 3'd4
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [CHAN_W-1:0]  chan;
  logic [CHAN_W-1:0]  last_grant;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [TMO_W-1:0]   cnt_inc;

  logic               grant;
  logic               hs;
  logic               tmo_fire;

  logic               found_hi;
  logic               found_lo;
  logic [CHAN_W-1:0]  pick_hi;
  logic [CHAN_W-1:0]  pick_lo;
  logic [CHAN_W-1:0]  pick_chan;
  logic [HDR_W-1:0]   fetch_hdr;

  // Circular search from last_grant+1: the lowest requester above the last
  // grant wins; if there is none, the lowest requester at or below it wins.
  // Descending loops leave the lowest matching index as the final assignment.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int k = N_CHAN - 1; k >= 0; k--) begin
      if (hdr_rdy[k]) begin
        if (CHAN_W'(k) > last_grant) begin
          found_hi = 1'b1;
          pick_hi  = CHAN_W'(k);
        end else begin
          found_lo = 1'b1;
          pick_lo  = CHAN_W'(k);
        end
      end
    end
    pick_chan = found_hi ? pick_hi : pick_lo;
  end

  // Read-data mux for the granted channel and the one-hot pop strobe.
  always_comb begin
    fetch_hdr = '0;
    hdr_rd_en = '0;
    for (int k = 0; k < N_CHAN; k++) begin
      if (chan == CHAN_W'(k)) begin
        fetch_hdr    = hdr_data[k*HDR_W +: HDR_W];
        hdr_rd_en[k] = (state == S_POP);
      end
    end
  end

  // Saturating increment so a very long BUSY never wraps back below the limit.
  assign cnt_inc = (&tmo_cnt) ? tmo_cnt : tmo_cnt + TMO_W'(1);

  // Next-state and control strobes.
  always_comb begin
    state_n  = state;
    grant    = 1'b0;
    hs       = 1'b0;
    tmo_fire = 1'b0;
    case (state)
      S_IDLE: begin
        if (en && (found_hi || found_lo)) begin
          grant   = 1'b1;
          state_n = S_POP;
        end
      end
      S_POP:   state_n = S_FETCH;
      // FIFO read data is registered, so it is valid the cycle after the pop.
      S_FETCH: state_n = S_PRESENT;
      S_PRESENT: begin
        if (sel_ready) begin
          hs      = 1'b1;
          state_n = S_BUSY;
        end
      end
      S_BUSY: begin
        // Completion wins over a timeout landing in the same cycle.
        if (rdout_done) begin
          state_n = S_IDLE;
        end else if ((tmo_limit != '0) && (cnt_inc >= tmo_limit)) begin
          tmo_fire = 1'b1;
          state_n  = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      chan       <= '0;
      last_grant <= CHAN_W'(N_CHAN - 1);
      sel_hdr    <= '0;
      sel_chan   <= '0;
      tmo_cnt    <= '0;
      tmo_err    <= 1'b0;
    end else begin
      state   <= state_n;
      tmo_err <= tmo_fire;
      if (grant) begin
        chan <= pick_chan;
      end
      if (state == S_FETCH) begin
        sel_hdr  <= fetch_hdr;
        sel_chan <= chan;
      end
      // The channel counts as granted once accepted, even if BUSY later times out.
      if (hs) begin
        last_grant <= chan;
        tmo_cnt    <= '0;
      end else if (state == S_BUSY) begin
        tmo_cnt <= cnt_inc;
      end
    end
  end

  assign sel_valid = (state == S_PRESENT);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_wvb_hdr_rr_sched.sv
module tb_wvb_hdr_rr_sched;

  localparam int N_CHAN = 24;
  localparam int HDR_W  = 106;
  localparam int CHAN_W = 5;
  localparam int TMO_W  = 16;
  localparam int W      = CHAN_W + HDR_W;

  logic                    clk;
  logic                    rst_n;
  logic                    en;
  logic [N_CHAN-1:0]       hdr_rdy;
  logic [N_CHAN*HDR_W-1:0] hdr_data;
  logic [N_CHAN-1:0]       hdr_rd_en;
  logic [HDR_W-1:0]        sel_hdr;
  logic [CHAN_W-1:0]       sel_chan;
  logic                    sel_valid;
  logic                    sel_ready;
  logic                    rdout_done;
  logic [TMO_W-1:0]        tmo_limit;
  logic                    busy;
  logic                    tmo_err;
  logic [2:0]              state_dbg;

  wvb_hdr_rr_sched #(
    .N_CHAN(N_CHAN), .HDR_W(HDR_W), .CHAN_W(CHAN_W), .TMO_W(TMO_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .hdr_rdy(hdr_rdy), .hdr_data(hdr_data),
    .hdr_rd_en(hdr_rd_en), .sel_hdr(sel_hdr), .sel_chan(sel_chan),
    .sel_valid(sel_valid), .sel_ready(sel_ready), .rdout_done(rdout_done),
    .tmo_limit(tmo_limit), .busy(busy), .tmo_err(tmo_err), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0]     exp_q[$];
  int               n_cmp;
  int               n_err;
  int               exp_pop[N_CHAN];
  int               rd_ch_cnt[N_CHAN];
  logic [HDR_W-1:0] rd_data[N_CHAN];
  int               fifo_pos[N_CHAN];
  logic [N_CHAN-1:0] churn;
  logic             auto_done;
  int               done_dly;

  function automatic logic [HDR_W-1:0] hdr_val(input int k, input int n);
    logic [7:0] kb;
    logic [7:0] nb;
    kb = 8'(k);
    nb = 8'(n);
    return {10'h2A5, kb, nb, 80'hC3A5_0F1E_2D3C_4B5A_6978};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Expected grant for the next header popped from channel ch.
  task automatic push_exp(input int ch);
    logic [CHAN_W-1:0] c;
    c = CHAN_W'(ch);
    exp_q.push_back({c, hdr_val(ch, exp_pop[ch])});
    exp_pop[ch]++;
  endtask

  // ---------------- FIFO model (registered read, 1-cycle latency) ----------------
  initial begin
    for (int k = 0; k < N_CHAN; k++) begin
      rd_data[k]   = '0;
      fifo_pos[k]  = 0;
      exp_pop[k]   = 0;
      rd_ch_cnt[k] = 0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < N_CHAN; k++) begin
      if (hdr_rd_en[k]) begin
        rd_data[k]  <= hdr_val(k, fifo_pos[k]);
        fifo_pos[k] <= fifo_pos[k] + 1;
      end else if (churn[k]) begin
        rd_data[k] <= HDR_W'({$urandom(), $urandom(), $urandom(), $urandom()});
      end
    end
  end

  always_comb begin
    hdr_data = '0;
    for (int k = 0; k < N_CHAN; k++) hdr_data[k*HDR_W +: HDR_W] = rd_data[k];
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (hdr_rd_en != '0) begin
        check("rd_en_onehot", 128'($onehot(hdr_rd_en)), 128'(1));
        for (int k = 0; k < N_CHAN; k++) if (hdr_rd_en[k]) rd_ch_cnt[k]++;
      end
      if (sel_valid && sel_ready) begin
        if (exp_q.size() == 0) begin
          timeout_fail("unexpected_grant");
        end else begin
          check("grant", 128'({sel_chan, sel_hdr}), 128'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- readout engine responder ----------------
  initial begin
    rdout_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && sel_valid && sel_ready && auto_done) begin
        @(posedge clk);
        repeat (done_dly) @(posedge clk);
        #1 rdout_done = 1'b1;
        @(posedge clk);
        #1 rdout_done = 1'b0;
      end
    end
  end

  // ---------------- driver / wait tasks ----------------
  task automatic wait_rd(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (hdr_rd_en != '0) break;
    end
    if (i == budget) timeout_fail(name);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sel_valid) break;
    end
    if (i == budget) timeout_fail(name);
  endtask

  task automatic wait_hs(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sel_valid && sel_ready) break;
    end
    if (i == budget) timeout_fail(name);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) break;
    end
    if (i == budget) timeout_fail(name);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rd_en"},     128'(hdr_rd_en), 128'(0));
    check({tag, "_sel_valid"}, 128'(sel_valid), 128'(0));
    check({tag, "_sel_hdr"},   128'(sel_hdr),   128'(0));
    check({tag, "_sel_chan"},  128'(sel_chan),  128'(0));
    check({tag, "_busy"},      128'(busy),      128'(0));
    check({tag, "_tmo_err"},   128'(tmo_err),   128'(0));
  endtask

  // Reset asserted for exactly one rising edge, from a negedge.
  task automatic pulse_reset_one();
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    hdr_rdy = '0;
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    summary();
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    logic saw;
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    en         = 1'b1;
    hdr_rdy    = '0;
    sel_ready  = 1'b1;
    tmo_limit  = '0;
    churn      = '0;
    auto_done  = 1'b1;
    done_dly   = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request on channel 2, latency t+1 / t+3
    @(posedge clk);
    #1 hdr_rdy = 24'h000004;
    push_exp(2);
    @(negedge clk);
    check("t1_rd_en_t0", 128'(hdr_rd_en), 128'(0));
    @(posedge clk);
    #1 hdr_rdy = '0;
    @(negedge clk);
    check("t1_rd_en_t1", 128'(hdr_rd_en), 128'(24'h000004));
    @(negedge clk);
    check("t1_rd_en_t2", 128'(hdr_rd_en), 128'(0));
    check("t1_valid_t2", 128'(sel_valid), 128'(0));
    @(negedge clk);
    check("t1_valid_t3", 128'(sel_valid), 128'(1));
    check("t1_chan_t3",  128'(sel_chan),  128'(2));
    wait_idle("t1_idle", 40);

    // Fairness: channels 0, 3, 23 always requesting
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    done_dly = 2;
    for (int r = 0; r < 2; r++) begin
      push_exp(0);
      push_exp(3);
      push_exp(23);
    end
    hdr_rdy = 24'h800009;
    for (int j = 0; j < 6; j++) wait_rd("fair_rd", 60);
    hdr_rdy = '0;
    wait_idle("fair_idle", 60);

    // Backpressure on channel 5 with churning read data
    @(posedge clk);
    #1 sel_ready = 1'b0;
    churn   = 24'h000020;
    hdr_rdy = 24'h000020;
    push_exp(5);
    wait_valid("bp_valid", 20);
    hdr_rdy = '0;
    for (int j = 0; j < 10; j++) begin
      check("bp_valid_hold", 128'(sel_valid), 128'(1));
      check("bp_hdr_hold",   128'(sel_hdr),   128'(hdr_val(5, 0)));
      @(negedge clk);
    end
    @(posedge clk);
    #1 sel_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_hs", 128'(sel_valid), 128'(1));
    @(negedge clk);
    check("bp_valid_after", 128'(sel_valid), 128'(0));
    wait_idle("bp_idle", 40);
    churn = '0;
    check("bp_one_pop", 128'(rd_ch_cnt[5]), 128'(1));

    // Enable gating: drop en during PRESENT
    @(posedge clk);
    #1 sel_ready = 1'b0;
    hdr_rdy = 24'h000080;
    push_exp(7);
    wait_valid("en_valid", 20);
    en      = 1'b0;
    hdr_rdy = 24'hFFFFFF;
    @(posedge clk);
    #1 sel_ready = 1'b1;
    wait_idle("en_idle", 40);
    cnt = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (hdr_rd_en != '0) cnt++;
    end
    check("en_no_pop", 128'(cnt), 128'(0));
    check("en_not_busy", 128'(busy), 128'(0));
    push_exp(8);
    @(posedge clk);
    #1 en = 1'b1;
    wait_rd("en_resume_rd", 10);
    check("en_resume_ch8", 128'(hdr_rd_en), 128'(24'h000100));
    hdr_rdy = '0;
    wait_idle("en_resume_idle", 40);

    // Timeout with limit 8
    @(posedge clk);
    #1 auto_done = 1'b0;
    tmo_limit = 16'd8;
    hdr_rdy   = 24'h000200;
    push_exp(9);
    wait_rd("tmo_rd", 10);
    hdr_rdy = '0;
    wait_hs("tmo_hs", 20);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check($sformatf("tmo_err_c%0d", i), 128'(tmo_err), 128'(i == 9));
      if (i == 9) check("tmo_idle", 128'(busy), 128'(0));
    end

    // Timeout disabled: stays in BUSY
    @(posedge clk);
    #1 tmo_limit = '0;
    hdr_rdy = 24'h000400;
    push_exp(10);
    wait_rd("tmo0_rd", 10);
    hdr_rdy = '0;
    wait_hs("tmo0_hs", 20);
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tmo_err || !busy) saw = 1'b1;
    end
    check("tmo0_stays_busy", 128'(saw), 128'(0));
    @(posedge clk);
    #1 rdout_done = 1'b1;
    @(posedge clk);
    #1 rdout_done = 1'b0;
    wait_idle("tmo0_idle", 20);

    // Reset during POP
    @(posedge clk);
    #1 sel_ready = 1'b0;
    hdr_rdy = 24'h000800;
    wait_rd("rp_rd", 10);
    exp_pop[11]++;
    pulse_reset_one();
    @(negedge clk);
    check_zero("rst_pop");

    // Reset during PRESENT
    @(posedge clk);
    #1 hdr_rdy = 24'h000800;
    wait_valid("rv_valid", 20);
    exp_pop[11]++;
    hdr_rdy = '0;
    pulse_reset_one();
    @(negedge clk);
    check_zero("rst_present");

    // Reset during BUSY
    @(posedge clk);
    #1 sel_ready = 1'b1;
    hdr_rdy = 24'h000800;
    push_exp(11);
    wait_rd("rb_rd", 10);
    hdr_rdy = '0;
    wait_hs("rb_hs", 20);
    @(negedge clk);
    check("rb_in_busy", 128'(busy), 128'(1));
    pulse_reset_one();
    @(negedge clk);
    check_zero("rst_busy");

    // First grant after reset starts at channel 0
    @(posedge clk);
    #1 auto_done = 1'b1;
    done_dly = 0;
    hdr_rdy  = 24'h800001;
    push_exp(0);
    wait_rd("post_rst_rd", 10);
    check("post_rst_ch0", 128'(hdr_rd_en), 128'(24'h000001));
    hdr_rdy = '0;
    wait_idle("post_rst_idle", 40);

    check("queue_empty", 128'(exp_q.size()), 128'(0));
    summary();
    $finish;
  end

endmodule

// File: doc/wvb_hdr_rr_sched.md
Name: wvb_hdr_rr_sched

Overview:
- Round-robin scheduler sharing one waveform-readout engine among N_CHAN per-channel waveform-buffer header FIFOs.
- Each FIFO entry is a 106-bit mDOM header bundle. Field layout: evt_ltc[48:0], start_addr[60:49], stop_addr[72:61], trig_src[74:73], cnst_run[75], pre_conf[80:76], sync_rdy[81], bsum[100:82], bsum_len_sel[103:101], bsum_valid[104], local_coinc[105].
- The block pops one header, presents it with its channel number to the readout engine, then waits for readout completion before the next grant.
- It sits between the channel wvb header FIFOs and the shared readout/formatter.

Parameters:
N_CHAN, 24, number of channels/requesters (2..32)
HDR_W, 106, header bundle width
CHAN_W, 5, channel index width; must be at least clog2(N_CHAN)
TMO_W, 16, width of the BUSY timeout counter

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
en  in  1  arbitration enable; gates new grants only
hdr_rdy  in  N_CHAN  per-channel FIFO non-empty
hdr_data  in  N_CHAN*HDR_W  per-channel FIFO read data; channel k at [k*HDR_W +: HDR_W]
hdr_rd_en  out  N_CHAN  one-hot single-cycle FIFO pop
sel_hdr  out  HDR_W  captured header of granted channel
sel_chan  out  CHAN_W  granted channel index
sel_valid  out  1  sel_hdr/sel_chan valid
sel_ready  in  1  readout engine accepts header
rdout_done  in  1  single-cycle pulse, readout of granted buffer finished
tmo_limit  in  TMO_W  BUSY timeout in cycles; 0 disables the timeout
busy  out  1  high in every state except IDLE
tmo_err  out  1  single-cycle pulse on timeout abort

Behaviour:
- Reset (rst_n=0 at a clk edge) forces the following, regardless of current state:
  - state=IDLE; hdr_rd_en=0; sel_valid=0; sel_hdr=0; sel_chan=0; busy=0; tmo_err=0; timeout counter=0.
  - Last-grant pointer=N_CHAN-1, so the first search starts at channel 0.
  - A transaction in progress when reset is applied is dropped; an already-popped header is lost.
- Channel selection: the first set bit of hdr_rdy, searching circularly from last_grant+1 and wrapping past N_CHAN-1 to 0.
- States and transitions:
  - IDLE: if en=1 and hdr_rdy!=0, register chan=selected and go to POP. Otherwise stay.
  - POP (1 cycle): hdr_rd_en[chan]=1. Go to FETCH.
  - FETCH (1 cycle): capture hdr_data[chan] into sel_hdr and chan into sel_chan. Set sel_valid=1 from the next cycle. Go to PRESENT. The FIFO has 1-cycle registered read latency (not FWFT).
  - PRESENT: hold sel_valid, sel_hdr and sel_chan stable until sel_ready=1. On the handshake cycle, sel_valid drops the next cycle, last_grant=chan, and state goes to BUSY.
  - BUSY: wait for rdout_done=1, then go to IDLE.
- Latency: hdr_rdy seen in IDLE at cycle t gives hdr_rd_en at t+1 and sel_valid at t+3.
- Back-to-back minimum: IDLE is re-entered after rdout_done, and the next grant is decided in that IDLE cycle.
- rdout_done is ignored in every state except BUSY. sel_ready is ignored unless sel_valid=1.
- Timeout counter:
  - Cleared on BUSY entry and increments every BUSY cycle.
  - If tmo_limit!=0 and the count reaches tmo_limit without rdout_done: tmo_err pulses 1 cycle and state goes to IDLE. The channel still counts as granted.
  - rdout_done in the same cycle as the limit is reached counts as normal completion; tmo_err=0.
  - The counter saturates at all-ones and does not wrap.
- en=0 never aborts a transaction in progress; it only blocks the IDLE->POP transition.
- hdr_rdy of the granted channel dropping after the grant decision is ignored; the pop still occurs.
- Header content is passed through unmodified; no field is interpreted.

Test Plan:
- Single request: hdr_rdy=0x000004, ch2 header=106'h2A5..., sel_ready=1 held → hdr_rd_en=0x000004 one cycle at t+1, sel_valid at t+3, sel_chan=2, sel_hdr exact match.
- Fairness: hdr_rdy bits 0, 3 and 23 held high, rdout_done pulsed 2 cycles into each BUSY → grant order 0, 3, 23, 0, 3, 23; no channel granted twice in a row.
- Backpressure: sel_ready=0 for 10 cycles while ch5's hdr_data changes every cycle → sel_valid stays 1 and sel_hdr holds the value captured in FETCH; accepted on the first sel_ready=1; exactly one hdr_rd_en pulse.
- Enable gating: en dropped during PRESENT → current transaction completes through BUSY; no new POP while en=0 with hdr_rdy=0xFFFFFF; resumes on en=1 from last_grant+1.
- Timeout: tmo_limit=8, no rdout_done → tmo_err pulses exactly 8 cycles after BUSY entry, returns to IDLE; tmo_limit=0 → remains in BUSY indefinitely.
- Reset mid-operation: rst_n=0 for one cycle during POP, PRESENT and BUSY respectively → all outputs 0 next cycle; first subsequent grant with hdr_rdy=0x800001 is channel 0.
